// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
//
// Definitions shared by uart_transmitter and uart_receiver so that both ends
// agree on framing:
//   - FSM state encoding (3-bit localparams kept for compatibility with the
//     older receiver code that compares against raw values),
//   - parity-mode codes used by the PARITY parameter,
//   - the oversampling ratio of the shared baud generator,
//   - a helper that sizes the tick counter so it can reach both the bit
//     length and the (possibly longer) stop phase.
// -----------------------------------------------------------------------------
package uart_pkg;

    // FSM state encoding
    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] START  = 3'd1;
    localparam logic [2:0] DATA   = 3'd2;
    localparam logic [2:0] PARITY = 3'd3;
    localparam logic [2:0] STOP   = 3'd4;

    // Parity modes
    localparam int PAR_NONE = 0;
    localparam int PAR_EVEN = 1;
    localparam int PAR_ODD  = 2;

    // sample_tick pulses per bit period
    localparam int OVERSAMPLE = 16;

    // The tick counter must hold OVERSAMPLE-1 (needs 4 bits) and also
    // SB_TICK-1 for 1.5 / 2 stop bits (needs $clog2(SB_TICK) bits).
    function automatic int tick_width(input int sb_tick);
        int w;
        w = $clog2(sb_tick);
        return (w > 4) ? w : 4;
    endfunction

endpackage

// File: rtl/uart_transmitter.sv
// -----------------------------------------------------------------------------
// uart_transmitter
//
// Serialises one parallel word per request onto the UART tx line:
//   start bit (0), DBITS data bits LSB first, optional parity bit,
//   SB_TICK/16 stop bits (1).
// Every bit period is timed by counting the shared 16x oversampling strobe
// sample_tick; the counters never move without it.
//
// Parameters
//   DBITS    data bits per word (5..9)
//   SB_TICK  sample ticks in the stop phase (16 / 24 / 32)
//   PARITY   PAR_NONE, PAR_EVEN or PAR_ODD (see uart_pkg)
//
// Ports
//   clk_100MHz   in   system clock
//   reset        in   asynchronous, active-high reset
//   sample_tick  in   one-cycle 16x oversampling strobe
//   tx_start     in   send request, accepted only while tx_busy is low
//   data_in      in   word to send, sampled on the accept cycle only
//   tx_busy      out  high from the cycle after accept until the frame ends
//   tx_done      out  one-cycle pulse on the final stop-phase tick
//   tx           out  registered serial line, idle high
// -----------------------------------------------------------------------------
module uart_transmitter #(
    parameter int DBITS   = 8,
    parameter int SB_TICK = 16,
    parameter int PARITY  = 0
) (
    input  logic             clk_100MHz,
    input  logic             reset,
    input  logic             sample_tick,
    input  logic             tx_start,
    input  logic [DBITS-1:0] data_in,
    output logic             tx_busy,
    output logic             tx_done,
    output logic             tx
);

    import uart_pkg::*;

    // The module parameter PARITY shares its name with the state constant,
    // so the state is always referenced through the package scope.
    localparam logic [2:0] ST_PARITY = uart_pkg::PARITY;

    localparam int TICK_W  = tick_width(SB_TICK);
    localparam int NBITS_W = (DBITS > 1) ? $clog2(DBITS) : 1;

    localparam logic [TICK_W-1:0]  BIT_LAST   = TICK_W'(OVERSAMPLE - 1);
    localparam logic [TICK_W-1:0]  STOP_LAST  = TICK_W'(SB_TICK - 1);
    localparam logic [NBITS_W-1:0] NBITS_LAST = NBITS_W'(DBITS - 1);

    localparam bit HAS_PARITY = (PARITY != PAR_NONE);
    localparam bit ODD_PARITY = (PARITY == PAR_ODD);

    // -------------------------------------------------------------------------
    // State
    // -------------------------------------------------------------------------
    logic [2:0]         state_q,  state_d;
    logic [TICK_W-1:0]  tick_q,   tick_d;
    logic [NBITS_W-1:0] nbits_q,  nbits_d;
    logic [DBITS-1:0]   shift_q,  shift_d;
    logic               par_q,    par_d;
    logic               tx_q,     tx_d;

    // -------------------------------------------------------------------------
    // Next-state logic
    // tx_d is derived from the current state, so the line follows the FSM by
    // exactly one clock: the start bit appears on the edge after the accept
    // edge and the last stop tick is still driven high.
    // -------------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        tick_d  = tick_q;
        nbits_d = nbits_q;
        shift_d = shift_q;
        par_d   = par_q;
        tx_d    = tx_q;

        case (state_q)
            IDLE: begin
                tx_d = 1'b1;
                // sample_tick is deliberately ignored here; the frame starts
                // on the accept itself, not on a tick boundary.
                if (tx_start) begin
                    shift_d = data_in;
                    par_d   = ODD_PARITY ? ~(^data_in) : ^data_in;
                    tick_d  = '0;
                    state_d = START;
                end
            end

            START: begin
                tx_d = 1'b0;
                if (sample_tick) begin
                    if (tick_q == BIT_LAST) begin
                        tick_d  = '0;
                        nbits_d = '0;
                        state_d = DATA;
                    end else begin
                        tick_d = tick_q + 1'b1;
                    end
                end
            end

            DATA: begin
                tx_d = shift_q[0];
                if (sample_tick) begin
                    if (tick_q == BIT_LAST) begin
                        tick_d  = '0;
                        shift_d = shift_q >> 1;
                        if (nbits_q == NBITS_LAST) begin
                            state_d = HAS_PARITY ? ST_PARITY : STOP;
                        end else begin
                            nbits_d = nbits_q + 1'b1;
                        end
                    end else begin
                        tick_d = tick_q + 1'b1;
                    end
                end
            end

            ST_PARITY: begin
                tx_d = par_q;
                if (sample_tick) begin
                    if (tick_q == BIT_LAST) begin
                        tick_d  = '0;
                        state_d = STOP;
                    end else begin
                        tick_d = tick_q + 1'b1;
                    end
                end
            end

            STOP: begin
                tx_d = 1'b1;
                // A tx_start arriving on the final tick is not seen: the FSM
                // only samples requests in IDLE, one clock later.
                if (sample_tick) begin
                    if (tick_q == STOP_LAST) begin
                        tick_d  = '0;
                        state_d = IDLE;
                    end else begin
                        tick_d = tick_q + 1'b1;
                    end
                end
            end

            default: begin
                // Unreachable encodings recover to an idle line.
                tx_d    = 1'b1;
                tick_d  = '0;
                state_d = IDLE;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Registers. Reset abandons any frame in flight and forces the line high.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk_100MHz or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            tick_q  <= '0;
            nbits_q <= '0;
            shift_q <= '0;
            par_q   <= 1'b0;
            tx_q    <= 1'b1;
        end else begin
            state_q <= state_d;
            tick_q  <= tick_d;
            nbits_q <= nbits_d;
            shift_q <= shift_d;
            par_q   <= par_d;
            tx_q    <= tx_d;
        end
    end

    // -------------------------------------------------------------------------
    // Outputs
    // tx_done is combinational so that it coincides with the final stop tick
    // rather than trailing it by a clock.
    // -------------------------------------------------------------------------
    assign tx      = tx_q;
    assign tx_busy = (state_q != IDLE);
    assign tx_done = (state_q == STOP) && sample_tick && (tick_q == STOP_LAST);

endmodule

// File: tb/tb_uart_transmitter.sv
// -----------------------------------------------------------------------------
// tb_uart_transmitter
//
// Four transmitters with different framing share one clock, reset and
// sample_tick:
//   cfg0: 8N1   cfg1: 8E1   cfg2: 8O1   cfg3: 7 data bits, no parity, SB_TICK=32
// A reference model describes each frame as a list of line bits, where the
// bit on the line is bits[ticks_elapsed/16] (1 once past the last bit), and
// checks tx / tx_busy / tx_done every clock. Completed frames are decoded
// from mid-bit samples of the real tx line and compared against a vector
// table, hand-written corner sequences, and randomized traffic.
// -----------------------------------------------------------------------------
module tb_uart_transmitter;

    localparam int NCFG = 4;

    logic       clk_100MHz = 1'b0;
    logic       reset      = 1'b1;
    logic       sample_tick = 1'b0;
    logic [3:0] start_v    = 4'b0;
    logic [8:0] din [NCFG];
    wire  [3:0] tx_w;
    wire  [3:0] busy_w;
    wire  [3:0] done_w;

    always #5 clk_100MHz = ~clk_100MHz;

    function automatic int cfg_db(input int g);
        return (g == 3) ? 7 : 8;
    endfunction
    function automatic int cfg_sb(input int g);
        return (g == 3) ? 32 : 16;
    endfunction
    function automatic int cfg_par(input int g);
        return (g == 1) ? 1 : ((g == 2) ? 2 : 0);
    endfunction

    for (genvar gi = 0; gi < NCFG; gi++) begin : g_dut
        localparam int DB = (gi == 3) ? 7 : 8;
        localparam int SB = (gi == 3) ? 32 : 16;
        localparam int PR = (gi == 1) ? 1 : ((gi == 2) ? 2 : 0);
        uart_transmitter #(.DBITS(DB), .SB_TICK(SB), .PARITY(PR)) u_dut (
            .clk_100MHz (clk_100MHz),
            .reset      (reset),
            .sample_tick(sample_tick),
            .tx_start   (start_v[gi]),
            .data_in    (din[gi][DB-1:0]),
            .tx_busy    (busy_w[gi]),
            .tx_done    (done_w[gi]),
            .tx         (tx_w[gi])
        );
    end

    // ---------------------------------------------------------------- ticks
    int tick_mode  = 0;   // 0: every 4th clock, 1: random ~1 in 3
    int tick_phase = 0;
    always @(posedge clk_100MHz) begin
        #1;
        if (tick_mode == 0) begin
            sample_tick = (tick_phase == 3);
            tick_phase  = (tick_phase + 1) % 4;
        end else begin
            sample_tick = ($urandom_range(0, 2) == 0);
        end
    end

    // ---------------------------------------------------------------- checks
    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------------------------------------------------------- model
    bit         m_active [NCFG];
    bit         m_tx     [NCFG];
    int         m_k      [NCFG];
    int         m_nb     [NCFG];
    int         m_total  [NCFG];
    logic       m_bits   [NCFG][12];
    logic       cap      [NCFG][12];
    int         busy_clks[NCFG];
    int         busy_tick[NCFG];
    int         frames_done[NCFG];
    int         done_cnt [NCFG];
    int         rises    [NCFG];
    int         idle_run [NCFG];
    int         last_gap [NCFG];
    bit         prev_busy[NCFG];
    logic [8:0] last_data[NCFG];
    logic       last_par [NCFG];
    int         last_ticks[NCFG];
    int         last_busy[NCFG];

    initial begin
        for (int g = 0; g < NCFG; g++) begin
            m_active[g] = 0; m_tx[g] = 1; m_k[g] = 0; m_nb[g] = 0; m_total[g] = 0;
            busy_clks[g] = 0; busy_tick[g] = 0; frames_done[g] = 0; done_cnt[g] = 0;
            rises[g] = 0; idle_run[g] = 0; last_gap[g] = 0; prev_busy[g] = 0;
            last_data[g] = '0; last_par[g] = 1'b0; last_ticks[g] = 0; last_busy[g] = 0;
            din[g] = '0;
        end
    end

    always @(negedge clk_100MHz) begin
        int   idx;
        int   db;
        logic exp_done;
        logic p;
        for (int g = 0; g < NCFG; g++) begin
            db = cfg_db(g);
            if (reset) begin
                m_active[g] = 0;
                m_tx[g]     = 1;
            end
            exp_done = m_active[g] && sample_tick && (m_k[g] == m_total[g] - 1);
            check($sformatf("busy[%0d]", g), 32'(busy_w[g]), 32'(m_active[g]));
            check($sformatf("tx[%0d]", g),   32'(tx_w[g]),   32'(m_tx[g]));
            check($sformatf("done[%0d]", g), 32'(done_w[g]), 32'(exp_done));

            // observed activity
            if (done_w[g]) done_cnt[g]++;
            if (busy_w[g]) begin
                if (!prev_busy[g]) begin
                    rises[g]++;
                    last_gap[g]  = idle_run[g];
                    idle_run[g]  = 0;
                    busy_clks[g] = 0;
                    busy_tick[g] = 0;
                end
                busy_clks[g]++;
                if (sample_tick) busy_tick[g]++;
            end else begin
                idle_run[g]++;
            end
            prev_busy[g] = busy_w[g];

            // advance the model across the coming clock edge
            if (!reset) begin
                if (m_active[g]) begin
                    idx     = m_k[g] / 16;
                    m_tx[g] = (idx < m_nb[g]) ? m_bits[g][idx] : 1'b1;
                    if (sample_tick) begin
                        if ((m_k[g] % 16 == 8) && (idx < m_nb[g])) cap[g][idx] = tx_w[g];
                        m_k[g]++;
                        if (m_k[g] == m_total[g]) begin
                            last_data[g] = '0;
                            for (int i = 0; i < db; i++) last_data[g][i] = cap[g][1 + i];
                            last_par[g]   = (cfg_par(g) != 0) ? cap[g][db + 1] : 1'b0;
                            last_ticks[g] = busy_tick[g];
                            last_busy[g]  = busy_clks[g];
                            m_active[g]   = 0;
                            frames_done[g]++;
                            $display("frame cfg=%0d data=0x%03h par=%0b ticks=%0d busy_clks=%0d",
                                     g, last_data[g], last_par[g], last_ticks[g], last_busy[g]);
                        end
                    end
                end else begin
                    m_tx[g] = 1'b1;
                    if (start_v[g]) begin
                        m_bits[g][0] = 1'b0;
                        p = 1'b0;
                        for (int i = 0; i < db; i++) begin
                            m_bits[g][1 + i] = din[g][i];
                            p = p ^ din[g][i];
                        end
                        if (cfg_par(g) == 2) p = ~p;
                        m_nb[g] = 1 + db;
                        if (cfg_par(g) != 0) begin
                            m_bits[g][db + 1] = p;
                            m_nb[g] = db + 2;
                        end
                        m_total[g]  = m_nb[g] * 16 + cfg_sb(g);
                        m_k[g]      = 0;
                        m_active[g] = 1;
                    end
                end
            end
        end
    end

    // ---------------------------------------------------------------- stimulus
    task automatic send(input int g, input logic [8:0] d, input bit align);
        int n = 0;
        @(posedge clk_100MHz); #2;
        // Aligned sends assert tx_start on a tick cycle so the busy window is
        // exactly 4 clocks per tick.
        while (align && !sample_tick && n < 16) begin
            @(posedge clk_100MHz); #2;
            n++;
        end
        start_v[g] = 1'b1;
        din[g]     = d;
        @(posedge clk_100MHz); #2;
        start_v[g] = 1'b0;
        din[g]     = 9'($urandom);   // later data_in changes must not matter
    endtask

    task automatic wait_frame(input int g, input int target, input int bound);
        int n = 0;
        while (frames_done[g] < target && n < bound) begin
            @(posedge clk_100MHz);
            n++;
        end
        #2;
        check($sformatf("frame_complete[%0d]", g), 32'(frames_done[g]), 32'(target));
    endtask

    typedef struct {
        int         cfg;
        logic [8:0] data;
        logic       exp_par;
        int         exp_ticks;
    } vec_t;

    vec_t vecs [8];

    initial begin
        int f0, d0, r0, g;
        logic [8:0] d, mask;

        vecs[0] = '{0, 9'h055, 1'b0, 160};
        vecs[1] = '{1, 9'h007, 1'b1, 176};
        vecs[2] = '{2, 9'h007, 1'b0, 176};
        vecs[3] = '{1, 9'h000, 1'b0, 176};
        vecs[4] = '{3, 9'h07F, 1'b0, 160};
        vecs[5] = '{0, 9'h0A5, 1'b0, 160};
        vecs[6] = '{2, 9'h000, 1'b1, 176};
        vecs[7] = '{3, 9'h02A, 1'b0, 160};

        // reset state
        repeat (3) @(posedge clk_100MHz);
        #2;
        check("reset_tx",   32'(tx_w),   32'hF);
        check("reset_busy", 32'(busy_w), 32'h0);
        check("reset_done", 32'(done_w), 32'h0);
        reset = 1'b0;
        repeat (2) @(posedge clk_100MHz);
        #2;
        check("idle_tx",   32'(tx_w),   32'hF);
        check("idle_busy", 32'(busy_w), 32'h0);

        // table-driven frames
        for (int v = 0; v < 8; v++) begin
            g  = vecs[v].cfg;
            f0 = frames_done[g];
            d0 = done_cnt[g];
            send(g, vecs[v].data, 1'b1);
            wait_frame(g, f0 + 1, 3000);
            check($sformatf("vec%0d_data", v),  32'(last_data[g]), 32'(vecs[v].data));
            if (cfg_par(g) != 0)
                check($sformatf("vec%0d_parity", v), 32'(last_par[g]), 32'(vecs[v].exp_par));
            check($sformatf("vec%0d_ticks", v), 32'(last_ticks[g]), 32'(vecs[v].exp_ticks));
            check($sformatf("vec%0d_busy_clks", v), 32'(last_busy[g]), 32'(vecs[v].exp_ticks * 4));
            check($sformatf("vec%0d_done_pulses", v), 32'(done_cnt[g] - d0), 32'd1);
        end

        // request mid-frame is ignored
        f0 = frames_done[0]; d0 = done_cnt[0]; r0 = rises[0];
        send(0, 9'h03C, 1'b1);
        repeat (200) @(posedge clk_100MHz);
        #2;
        start_v[0] = 1'b1; din[0] = 9'h0A3;
        @(posedge clk_100MHz); #2;
        start_v[0] = 1'b0;
        wait_frame(0, f0 + 1, 3000);
        repeat (300) @(posedge clk_100MHz);
        #2;
        check("midreq_data",   32'(last_data[0]), 32'h03C);
        check("midreq_done",   32'(done_cnt[0] - d0), 32'd1);
        check("midreq_frames", 32'(rises[0] - r0), 32'd1);

        // tx_start held high: back-to-back frames, 1-clock idle gap
        f0 = frames_done[0];
        @(posedge clk_100MHz); #2;
        start_v[0] = 1'b1; din[0] = 9'h081;
        for (int k = 1; k <= 3; k++) begin
            wait_frame(0, f0 + k, 3000);
            check($sformatf("b2b%0d_data", k), 32'(last_data[0]), 32'h081);
            repeat (3) @(posedge clk_100MHz);
            #2;
            check($sformatf("b2b%0d_gap", k), 32'(last_gap[0]), 32'd1);
        end
        start_v[0] = 1'b0;
        wait_frame(0, f0 + 4, 3000);
        check("b2b4_data", 32'(last_data[0]), 32'h081);

        // reset during data bit 3 of 0xF0
        f0 = frames_done[0]; d0 = done_cnt[0];
        send(0, 9'h0F0, 1'b1);
        begin
            int n = 0;
            while (m_k[0] < 70 && n < 2000) begin
                @(posedge clk_100MHz);
                n++;
            end
        end
        #2;
        check("prereset_tx", 32'(tx_w[0]), 32'd0);
        reset = 1'b1;
        #1;
        check("midreset_tx",   32'(tx_w[0]),   32'd1);
        check("midreset_busy", 32'(busy_w[0]), 32'd0);
        repeat (2) @(posedge clk_100MHz);
        #2;
        reset = 1'b0;
        check("midreset_no_done",  32'(done_cnt[0] - d0),   32'd0);
        check("midreset_no_frame", 32'(frames_done[0] - f0), 32'd0);
        send(0, 9'h012, 1'b1);
        wait_frame(0, f0 + 1, 3000);
        check("postreset_data",  32'(last_data[0]),  32'h012);
        check("postreset_ticks", 32'(last_ticks[0]), 32'd160);

        // randomized traffic with irregular ticks and ignored extra requests
        tick_mode = 1;
        for (int it = 0; it < 24; it++) begin
            g    = $urandom_range(0, NCFG - 1);
            d    = 9'($urandom);
            mask = 9'((1 << cfg_db(g)) - 1);
            f0   = frames_done[g];
            d0   = done_cnt[g];
            send(g, d, 1'b0);
            repeat ($urandom_range(10, 250)) @(posedge clk_100MHz);
            #2;
            start_v[g] = 1'b1; din[g] = 9'($urandom);
            @(posedge clk_100MHz); #2;
            start_v[g] = 1'b0;
            wait_frame(g, f0 + 1, 6000);
            check($sformatf("rand%0d_data", it), 32'(last_data[g]), 32'(d & mask));
            check($sformatf("rand%0d_done", it), 32'(done_cnt[g] - d0), 32'd1);
            repeat (3) @(posedge clk_100MHz);
        end

        repeat (5) @(posedge clk_100MHz);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached, errors=%0d of %0d checks", errors, checks);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/uart_transmitter.md
# uart_transmitter

Serialises one parallel data word per request onto the UART `tx` line: 1 start bit, DBITS data bits LSB-first, optional parity bit, and SB_TICK/16 stop bits. Bit timing comes from the shared 16× oversampling `sample_tick` of the baud rate generator. The block sits between the transmit FIFO (read side) and the board `tx` pin. It is the transmit counterpart of `uart_receiver`, and both use identical framing.

## Interface
- `DBITS`, 8, data bits per word (5..9).
- `SB_TICK`, 16, sample ticks in the stop phase (16 = 1 stop bit, 24 = 1.5, 32 = 2).
- `PARITY`, 0, parity mode: 0 none, 1 even, 2 odd.
- `clk_100MHz`  in  1  system clock.
- `reset`  in  1  asynchronous, active-high reset.
- `sample_tick`  in  1  one-cycle 16× oversampling strobe from the baud generator.
- `tx_start`  in  1  request to send `data_in`; accepted only while `tx_busy`=0.
- `data_in`  in  DBITS  word to send; sampled on the accept cycle only.
- `tx_busy`  out  1  high from the cycle after accept until the frame ends.
- `tx_done`  out  1  one-cycle pulse on the final stop-phase tick.
- `tx`  out  1  serial line, registered, idle high.

## Operation
- State machine states: `IDLE`, `START`, `DATA`, `PARITY`, `STOP`.
- Registers:
  - `state`
  - `tick_reg` (4 bits; widened to $clog2(SB_TICK) if larger)
  - `nbits_reg` ($clog2(DBITS) bits)
  - `shift_reg` (DBITS)
  - `par_reg` (1)
  - `tx_reg` (1)
- `IDLE`: `tx_reg`=1. If `tx_start`=1: load `shift_reg`=`data_in`, `par_reg`=^`data_in` (inverted for odd parity), `tick_reg`=0, go to `START`. If `tx_start`=0: stay in `IDLE`.
- `START`: `tx_reg`=0. On each `sample_tick`, increment `tick_reg`. On the tick where `tick_reg`==15: set `tick_reg`=0, `nbits_reg`=0, go to `DATA`.
- `DATA`: `tx_reg`=`shift_reg`[0]. On the tick where `tick_reg`==15:
  - shift right and clear `tick_reg`;
  - if `nbits_reg`==DBITS-1, go to `PARITY` (PARITY≠0) or `STOP` (PARITY=0);
  - otherwise increment `nbits_reg`.
- `PARITY`: `tx_reg`=`par_reg`. 16 ticks, then go to `STOP` with `tick_reg`=0.
- `STOP`: `tx_reg`=1. On the tick where `tick_reg`==SB_TICK-1: assert `tx_done` (combinational, same cycle) and go to `IDLE`.
- `tx_busy` = (state≠`IDLE`).
- `sample_tick` is ignored in `IDLE`. Counters advance only on `sample_tick`.
- `tx_start` while busy is ignored. No queuing. `data_in` changes during a frame have no effect.
- `tx_start` in the same cycle as `tx_done` is ignored: the FSM is still in `STOP` that cycle. The FIFO reasserts on the next cycle, which gives back-to-back frames with a 1-clock idle gap.
- Reset mid-frame: immediately return to `IDLE` and drive `tx`=1. The partial frame is abandoned and no `tx_done` is issued.

## Timing
- Reset values: `tx`=1, `tx_busy`=0, `tx_done`=0, all counters and `shift_reg` = 0, `state`=`IDLE`.
- `tx` is a flop output. It falls on the clock edge after the `tx_start` accept edge, so the accept-to-line latency is 1 clock.
- Each bit period (start, data, parity) spans exactly 16 `sample_tick`s.
- Frame length in ticks = (1+DBITS+(PARITY≠0))·16 + SB_TICK. For example, the default 8N1 frame is 160 ticks.
- `tx_done` is high for exactly one clock and coincides with the final stop tick.
- `tx_busy` deasserts on the clock after `tx_done`.

## Structure
- Shared package/include `uart_pkg`, used by both `uart_transmitter` and `uart_receiver`, holds:
  - state encoding localparams (`IDLE`, `START`, `DATA`, `PARITY`, `STOP`, 3 bits);
  - parity-mode constants (`PAR_NONE`, `PAR_EVEN`, `PAR_ODD`);
  - the `OVERSAMPLE`=16 constant.
- Single module with no sub-module. The baud generator is external and shared with the receiver.

## Test plan
- 8N1, `sample_tick` every 4 clocks, send 0x55 → `tx` pattern 0,1,0,1,0,1,0,1,0,1 with each bit 64 clocks, then 1 for 64 clocks; one `tx_done` pulse; `tx_busy` high for 640 clocks.
- PARITY=1, send 0x07 → parity bit 1. PARITY=2, send 0x07 → parity bit 0. Send 0x00 with even parity → parity bit 0.
- Assert `tx_start` with 0xA3 mid-frame of 0x3C → 0x3C is sent intact, 0xA3 never appears, and `tx_done` pulses exactly once.
- `tx_start` held high continuously with `data_in`=0x81 → back-to-back frames with a 1-clock high gap between stop and start; each frame decodes to 0x81 via a loopback into `uart_receiver`.
- Assert `reset` during data bit 3 of 0xF0 → `tx`=1 immediately, `tx_busy`=0, no `tx_done`; the next request (0x12) transmits correctly.
- SB_TICK=32, DBITS=7, send 0x7F → the stop phase lasts 32 ticks and the frame totals 160 ticks.
